// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Request/response handshake bundle for one requester of the
//               shared-ALU arbiter.
//               master modport : requester side (drives req_*, rsp_ready)
//               slave modport  : arbiter side   (drives req_ready, rsp_*)
//               req_valid/req_ready     request handshake
//               req_a/req_b/req_op      operands and opcode
//               rsp_valid/rsp_ready     response handshake
//               rsp_data/rsp_err        result and illegal-opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters. Each port owns a single registered response slot.
//               clk, rst        clock, asynchronous active-high reset
//               p0, p1          requester handshake bundles (slave side)
//               alu_a/b/op      operands/opcode driven to the shared ALU
//               alu_result      combinational ALU result
//               contention_cnt  saturating count of cycles both ports eligible
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  p0,
  alu_share_arbiter_if.slave  p1,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OPW-1:0]      alu_op,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [CNTW-1:0]     contention_cnt
);

  localparam logic [OPW-1:0] c_OP_ADD = OPW'(5'b00001);
  localparam logic [OPW-1:0] c_OP_SUB = OPW'(5'b00010);
  localparam logic [OPW-1:0] c_OP_XOR = OPW'(5'b00011);
  localparam logic [OPW-1:0] c_OP_OR  = OPW'(5'b00100);
  localparam logic [OPW-1:0] c_OP_AND = OPW'(5'b00101);
  localparam logic [OPW-1:0] c_OP_SLT = OPW'(5'b01001);

  logic [1:0]      w_req_valid;
  logic [1:0]      w_rsp_ready;
  logic [1:0]      w_slot_valid;
  logic [1:0]      w_free;
  logic [1:0]      w_elig;
  logic [1:0]      w_grant;
  logic            w_legal;

  // last_grant_q = 1 means port 1 was granted most recently
  logic            last_grant_q;
  logic            last_grant_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  assign w_req_valid = {p1.req_valid, p0.req_valid};
  assign w_rsp_ready = {p1.rsp_ready, p0.rsp_ready};

  // A slot that is being drained this cycle can be refilled on the same edge.
  assign w_free = ~w_slot_valid | w_rsp_ready;

  // Gating with rst keeps both ready outputs low throughout reset.
  assign w_elig = w_req_valid & w_free & {2{~rst}};

  assign w_grant[0] = w_elig[0] & (~w_elig[1] | last_grant_q);
  assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~last_grant_q);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (w_grant[0]) begin
      alu_a  = p0.req_a;
      alu_b  = p0.req_b;
      alu_op = p0.req_op;
    end else if (w_grant[1]) begin
      alu_a  = p1.req_a;
      alu_b  = p1.req_b;
      alu_op = p1.req_op;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (alu_op)
      c_OP_ADD, c_OP_SUB, c_OP_XOR, c_OP_OR, c_OP_AND, c_OP_SLT: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic             rsp_valid_q;
      logic             rsp_valid_d;
      logic [WIDTH-1:0] rsp_data_q;
      logic [WIDTH-1:0] rsp_data_d;
      logic             rsp_err_q;
      logic             rsp_err_d;

      // Data/err only change on a capture; a plain drain just clears valid.
      always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (w_grant[gi]) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = w_legal ? alu_result : '0;
          rsp_err_d   = ~w_legal;
        end else if (w_rsp_ready[gi]) begin
          rsp_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b0;
        end else begin
          rsp_valid_q <= rsp_valid_d;
          rsp_data_q  <= rsp_data_d;
          rsp_err_q   <= rsp_err_d;
        end
      end

      assign w_slot_valid[gi] = rsp_valid_q;
    end
  endgenerate

  always_comb begin
    last_grant_d = last_grant_q;
    if (|w_grant) begin
      last_grant_d = w_grant[1];
    end
    cnt_d = cnt_q;
    if ((&w_elig) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign p0.req_ready = w_grant[0];
  assign p1.req_ready = w_grant[1];
  assign p0.rsp_valid = g_port[0].rsp_valid_q;
  assign p0.rsp_data  = g_port[0].rsp_data_q;
  assign p0.rsp_err   = g_port[0].rsp_err_q;
  assign p1.rsp_valid = g_port[1].rsp_valid_q;
  assign p1.rsp_data  = g_port[1].rsp_data_q;
  assign p1.rsp_err   = g_port[1].rsp_err_q;

  assign contention_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. Provides the shared
//               ALU, a per-port response scoreboard, a vector table for single
//               operations and directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;
  localparam int CNTW  = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic [CNTW-1:0]  contention_cnt;
  logic [WIDTH:0]   w_env;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];

  alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) if0();
  alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) if1();

  alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0             (if0),
    .p1             (if1),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_result     (alu_result),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference operation: {illegal, result}; illegal ops must come back as zero.
  function automatic logic [WIDTH:0] ref_op(input logic [OPW-1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      5'd1:    return {1'b0, a + b};
      5'd2:    return {1'b0, a - b};
      5'd3:    return {1'b0, a ^ b};
      5'd4:    return {1'b0, a | b};
      5'd5:    return {1'b0, a & b};
      5'd9:    return {1'b0, {(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  // Shared ALU: produces garbage on illegal opcodes so zeroing is observable.
  assign w_env      = ref_op(alu_op, alu_a, alu_b);
  assign alu_result = w_env[WIDTH] ? (alu_a ^ alu_b ^ 32'hDEAD_BEEF) : w_env[WIDTH-1:0];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on response consumption, push on request transfer.
  logic [WIDTH:0] exp_r;
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (if0.rsp_valid && if0.rsp_ready) begin
        if (q0.size() == 0) chk("sb0_underflow", 64'd1, 64'd0);
        else begin
          exp_r = q0.pop_front();
          chk("sb0_rsp", {31'd0, if0.rsp_err, if0.rsp_data}, {31'd0, exp_r});
        end
      end
      if (if1.rsp_valid && if1.rsp_ready) begin
        if (q1.size() == 0) chk("sb1_underflow", 64'd1, 64'd0);
        else begin
          exp_r = q1.pop_front();
          chk("sb1_rsp", {31'd0, if1.rsp_err, if1.rsp_data}, {31'd0, exp_r});
        end
      end
      if (if0.req_valid && if0.req_ready) q0.push_back(ref_op(if0.req_op, if0.req_a, if0.req_b));
      if (if1.req_valid && if1.req_ready) q1.push_back(ref_op(if1.req_op, if1.req_a, if1.req_b));
    end
  end

  typedef struct {
    logic             port;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
    logic             err;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic port, input logic v, input logic [OPW-1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (port == 1'b0) begin
      if0.req_valid = v; if0.req_op = op; if0.req_a = a; if0.req_b = b;
    end else begin
      if1.req_valid = v; if1.req_op = op; if1.req_a = a; if1.req_b = b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 5'b00001, 32'd5,          32'd3,          32'd8,          1'b0};
    tbl[1] = '{1'b0, 5'b00010, 32'd10,         32'd4,          32'd6,          1'b0};
    tbl[2] = '{1'b1, 5'b00011, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1'b0};
    tbl[3] = '{1'b1, 5'b00100, 32'h0000_1200,  32'h0000_0034,  32'h0000_1234,  1'b0};
    tbl[4] = '{1'b0, 5'b00101, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0};
    tbl[5] = '{1'b0, 5'b01001, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[6] = '{1'b1, 5'b01001, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    tbl[7] = '{1'b0, 5'b00000, 32'd7,          32'd9,          32'd0,          1'b1};
    tbl[8] = '{1'b1, 5'b00110, 32'd2,          32'd3,          32'd0,          1'b1};
    tbl[9] = '{1'b1, 5'b00001, 32'd2,          32'd2,          32'd4,          1'b0};

    // Reset with all inputs known; port 0 asserts valid to prove ready is held low.
    rst = 1'b1;
    drive(1'b0, 1'b1, 5'd1, 32'd1, 32'd1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", {63'd0, if0.req_ready}, 64'd0);
    chk("rst_rsp0_valid", {63'd0, if0.rsp_valid}, 64'd0);
    chk("rst_rsp1_valid", {63'd0, if1.rsp_valid}, 64'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("post_rst_cnt",    {61'd0, contention_cnt}, 64'd0);
    chk("post_rst_alu_op", {59'd0, alu_op}, 64'd0);
    chk("post_rst_rsp0",   {63'd0, if0.rsp_valid}, 64'd0);

    // Single-port vectors: grant in cycle N, response in cycle N+1.
    for (int i = 0; i < 10; i++) begin
      step();
      drive(tbl[i].port, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),
          {63'd0, (tbl[i].port ? if1.req_ready : if0.req_ready)}, 64'd1);
      chk($sformatf("vec%0d_alu_op", i), {59'd0, alu_op}, {59'd0, tbl[i].op});
      step();
      drive(tbl[i].port, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i),
          {63'd0, (tbl[i].port ? if1.rsp_valid : if0.rsp_valid)}, 64'd1);
      chk($sformatf("vec%0d_data", i),
          {32'd0, (tbl[i].port ? if1.rsp_data : if0.rsp_data)}, {32'd0, tbl[i].exp});
      chk($sformatf("vec%0d_err", i),
          {63'd0, (tbl[i].port ? if1.rsp_err : if0.rsp_err)}, {63'd0, tbl[i].err});
    end

    // Tie: port 0 wins first (last grant was port 1), then port 1.
    step();
    drive(1'b0, 1'b1, 5'b00010, 32'd10, 32'd4);
    drive(1'b1, 1'b1, 5'b01001, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("tie_req0_ready", {63'd0, if0.req_ready}, 64'd1);
    chk("tie_req1_ready", {63'd0, if1.req_ready}, 64'd0);
    chk("tie_cnt0", {61'd0, contention_cnt}, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("tie_req1_ready2", {63'd0, if1.req_ready}, 64'd1);
    chk("tie_rsp0_data", {32'd0, if0.rsp_data}, 64'd6);
    chk("tie_cnt1", {61'd0, contention_cnt}, 64'd1);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("tie_rsp1_valid", {63'd0, if1.rsp_valid}, 64'd1);
    chk("tie_rsp1_data", {32'd0, if1.rsp_data}, 64'd1);

    // Sustained tie alternates 0,1,0,1...; counter saturates at 7.
    step();
    drive(1'b0, 1'b1, 5'b00001, 32'd100, 32'd1);
    drive(1'b1, 1'b1, 5'b00011, 32'h55, 32'hFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_g0", k), {63'd0, if0.req_ready}, {63'd0, (k % 2 == 0)});
      chk($sformatf("alt%0d_g1", k), {63'd0, if1.req_ready}, {63'd0, (k % 2 == 1)});
      if (k == 4) chk("alt_cnt_mid", {61'd0, contention_cnt}, 64'd5);
      step();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("cnt_saturated", {61'd0, contention_cnt}, 64'd7);

    // Hold on port 0 does not block port 1; then drain-and-refill.
    step();
    if0.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 5'b00001, 32'd1, 32'd1);
    @(negedge clk);
    chk("hold_first_ready", {63'd0, if0.req_ready}, 64'd1);
    step();
    drive(1'b0, 1'b1, 5'b00001, 32'd7, 32'd7);
    drive(1'b1, 1'b1, 5'b00011, 32'hF0, 32'hFF);
    @(negedge clk);
    chk("hold_req0_ready", {63'd0, if0.req_ready}, 64'd0);
    chk("hold_req1_ready", {63'd0, if1.req_ready}, 64'd1);
    chk("hold_rsp0_data", {32'd0, if0.rsp_data}, 64'd2);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("hold_req0_ready2", {63'd0, if0.req_ready}, 64'd0);
    chk("hold_rsp0_data2", {32'd0, if0.rsp_data}, 64'd2);
    chk("hold_rsp1_data", {32'd0, if1.rsp_data}, 64'h0F);
    step();
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("refill_req0_ready", {63'd0, if0.req_ready}, 64'd1);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("refill_rsp0_valid", {63'd0, if0.rsp_valid}, 64'd1);
    chk("refill_rsp0_data", {32'd0, if0.rsp_data}, 64'd14);

    // Asynchronous reset while a response is pending.
    step();
    if0.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 5'b00001, 32'd3, 32'd4);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("pre_arst_rsp0_valid", {63'd0, if0.rsp_valid}, 64'd1);
    chk("pre_arst_rsp0_data", {32'd0, if0.rsp_data}, 64'd7);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rsp0_valid", {63'd0, if0.rsp_valid}, 64'd0);
    chk("arst_cnt", {61'd0, contention_cnt}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if0.rsp_ready = 1'b1;
    step();
    drive(1'b0, 1'b1, 5'b00010, 32'd9, 32'd2);
    drive(1'b1, 1'b1, 5'b00001, 32'd1, 32'd1);
    @(negedge clk);
    chk("arst_tie_g0", {63'd0, if0.req_ready}, 64'd1);
    chk("arst_tie_g1", {63'd0, if1.req_ready}, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("arst_tie_g1b", {63'd0, if1.req_ready}, 64'd1);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (3) step();
    @(negedge clk);
    chk("sb0_empty", 64'(q0.size()), 64'd0);
    chk("sb1_empty", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
